// File: rtl/fpga_uart_pkg.sv
// fpga_uart_pkg: shared UART state type, baud divisor and parity helpers
package fpga_uart_pkg;
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_IDLE} uart_rx_state_t;
  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction
  // XOR of the low `width` bits, inverted for odd parity
  function automatic logic parity_bit(input logic [8:0] data, input int width, input logic odd);
    logic p;
    p = odd;
    for (int i = 0; i < 9; i++) p ^= (i < width) & data[i];
    return p;
  endfunction
endpackage

// File: rtl/fpga_uart_sync.sv
// fpga_uart_sync: N-stage flop synchroniser for asynchronous inputs
module fpga_uart_sync #(
  parameter int STAGES = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input logic clk_i,
  input logic arstn_i,
  input logic d_i,
  output logic q_o
);
  logic [STAGES-1:0] ff;
  always_ff @(posedge clk_i or negedge arstn_i)
    if (!arstn_i) ff <= {STAGES{RESET_VAL}};
    else ff <= {ff[STAGES-2:0], d_i};
  assign q_o = ff[STAGES-1];
endmodule

// File: rtl/fpga_uart_rx.sv
// fpga_uart_rx: UART receiver with mid-bit sampling, optional parity and valid/ready output
module fpga_uart_rx import fpga_uart_pkg::*; #(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int BAUD_RATE = 115_200,
  parameter int DATA_WIDTH = 8,
  parameter int PARITY_EN = 0,
  parameter int PARITY_ODD = 0
) (
  input logic clk_i,
  input logic arstn_i,
  input logic uart_rx_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic valid_o,
  input logic ready_i,
  output logic busy_o,
  output logic frame_err_o,
  output logic parity_err_o,
  output logic overrun_o
);
  localparam int CPB = clks_per_bit(CLK_FREQ_HZ, BAUD_RATE);
  localparam int CW = $clog2(CPB);
  localparam int IW = $clog2(DATA_WIDTH);
  uart_rx_state_t state, state_nxt;
  logic rx_s, rx_prev, tick, par_rx, load, frame_err, parity_err, overrun;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic [DATA_WIDTH-1:0] shreg;
  fpga_uart_sync #(.STAGES(2), .RESET_VAL(1'b1)) u_sync (
    .clk_i(clk_i), .arstn_i(arstn_i), .d_i(uart_rx_i), .q_o(rx_s)
  );
  // half-bit wait in START puts every later sample at a bit midpoint
  assign tick = cnt == ((state == S_START) ? CW'(CPB / 2 - 1) : CW'(CPB - 1));
  assign busy_o = state != S_IDLE;
  always_comb begin
    state_nxt = state;
    frame_err = 1'b0;
    parity_err = 1'b0;
    overrun = 1'b0;
    load = 1'b0;
    unique case (state)
      S_IDLE: if (rx_prev && !rx_s) state_nxt = S_START;
      S_START: if (tick) state_nxt = rx_s ? S_IDLE : S_DATA;
      S_DATA: if (tick && idx == IW'(DATA_WIDTH - 1)) state_nxt = (PARITY_EN != 0) ? S_PARITY : S_STOP;
      S_PARITY: if (tick) state_nxt = S_STOP;
      S_STOP:
        if (tick) begin
          state_nxt = rx_s ? S_IDLE : S_WAIT_IDLE;
          frame_err = !rx_s;
          parity_err = rx_s && PARITY_EN != 0 && par_rx != parity_bit(9'(shreg), DATA_WIDTH, PARITY_ODD != 0);
          overrun = rx_s && !parity_err && valid_o && !ready_i;
          load = rx_s && !parity_err && !overrun;
        end
      S_WAIT_IDLE: if (rx_s) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge arstn_i)
    if (!arstn_i) begin
      state <= S_IDLE;
      rx_prev <= 1'b1;
      cnt <= '0;
      idx <= '0;
      shreg <= '0;
      par_rx <= 1'b0;
      data_o <= '0;
      valid_o <= 1'b0;
      frame_err_o <= 1'b0;
      parity_err_o <= 1'b0;
      overrun_o <= 1'b0;
    end else begin
      state <= state_nxt;
      rx_prev <= rx_s;
      cnt <= (state == S_IDLE || tick) ? '0 : cnt + CW'(1);
      idx <= (state != S_DATA) ? '0 : idx + IW'(tick);
      if (state == S_DATA && tick) shreg <= {rx_s, shreg[DATA_WIDTH-1:1]};
      if (state == S_PARITY && tick) par_rx <= rx_s;
      if (load) data_o <= shreg;
      valid_o <= load | (valid_o & ~ready_i);
      frame_err_o <= frame_err;
      parity_err_o <= parity_err;
      overrun_o <= overrun;
    end
endmodule

// File: tb/tb_fpga_uart_rx.sv
// tb_fpga_uart_rx: randomized frames on 8N1 and 8E1 receivers against a frame-level model
module tb_fpga_uart_rx;
  localparam int CPB = 10;
  localparam int HALF = CPB / 2;
  localparam int STOP_AT = 2 + HALF + 9 * CPB;
  logic clk = 0, arstn = 0, rx = 1, rx_p = 1, ready = 0, ready_p = 0;
  logic [7:0] data, data_p;
  logic valid, busy, fe, pe, ov, valid_p, busy_p, fe_p, pe_p, ov_p, v_last = 0;
  int n_vec = 0, n_err = 0, cyc = 0, t0 = 0, rise_cyc = -1;
  int fe_cnt = 0, ov_cnt = 0, pe_cnt = 0, exp_fe = 0, exp_ov = 0, exp_pe = 0;
  logic m_valid = 0, mp_valid = 0;
  logic [7:0] m_data = 0, mp_data = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fpga_uart_rx #(.CLK_FREQ_HZ(100_000_000), .BAUD_RATE(10_000_000)) dut (
    .clk_i(clk), .arstn_i(arstn), .uart_rx_i(rx), .data_o(data), .valid_o(valid), .ready_i(ready),
    .busy_o(busy), .frame_err_o(fe), .parity_err_o(pe), .overrun_o(ov)
  );
  fpga_uart_rx #(.CLK_FREQ_HZ(100_000_000), .BAUD_RATE(10_000_000), .PARITY_EN(1), .PARITY_ODD(0)) dut_p (
    .clk_i(clk), .arstn_i(arstn), .uart_rx_i(rx_p), .data_o(data_p), .valid_o(valid_p), .ready_i(ready_p),
    .busy_o(busy_p), .frame_err_o(fe_p), .parity_err_o(pe_p), .overrun_o(ov_p)
  );

  always @(negedge clk) begin
    fe_cnt += int'(fe) + int'(pe);
    ov_cnt += int'(ov);
    pe_cnt += int'(pe_p) + int'(fe_p) * 100 + int'(ov_p) * 100;
    if (valid && !v_last) rise_cyc = cyc;
    v_last = valid;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic v);
    if (sel) rx_p = v;
    else rx = v;
  endtask

  task automatic pulse_ready(input bit sel);
    if (sel) ready_p = 1;
    else ready = 1;
    @(posedge clk); #1;
    ready = 0;
    ready_p = 0;
  endtask

  task automatic send_frame(input bit sel, input logic [7:0] b, input bit use_par, input bit par,
                            input bit stop, input int hold, input int gap);
    logic bits[$];
    bits = {1'b0};
    for (int i = 0; i < 8; i++) bits.push_back(b[i]);
    if (use_par) bits.push_back(par);
    bits.push_back(stop);
    @(posedge clk); #1;
    t0 = cyc;
    foreach (bits[i]) begin
      drive(sel, bits[i]);
      repeat (CPB) @(posedge clk);
      #1;
    end
    repeat (hold) begin @(posedge clk); #1; end
    drive(sel, 1'b1);
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  // mode 0: ready low; 1: ready pulse before frame; 2: ready high in the stop-sample cycle
  task automatic rx_frame(input logic [7:0] b, input bit stop, input int mode, input int hold, input int gap);
    bit hs;
    if (mode == 1) begin pulse_ready(0); m_valid = 0; end
    hs = (mode == 2) && m_valid;
    rise_cyc = -1;
    fork
      send_frame(0, b, 0, 0, stop, hold, gap);
      if (mode == 2) begin
        @(posedge clk);
        repeat (STOP_AT) @(posedge clk);
        #1 ready = 1;
        @(posedge clk);
        #1 ready = 0;
      end
    join
    if (!stop) begin exp_fe++; if (hs) m_valid = 0; end
    else if (m_valid && !hs) exp_ov++;
    else begin m_valid = 1; m_data = b; end
    chk("valid", 32'(valid), 32'(m_valid));
    chk("data", 32'(data), 32'(m_data));
    chk("err_pulses", fe_cnt, exp_fe);
    chk("overrun", ov_cnt, exp_ov);
  endtask

  task automatic p_frame(input logic [7:0] b, input bit par);
    pulse_ready(1);
    mp_valid = 0;
    send_frame(1, b, 1, par, 1, 0, 2);
    if (par != ^b) exp_pe++;
    else begin mp_valid = 1; mp_data = b; end
    chk("p_valid", 32'(valid_p), 32'(mp_valid));
    chk("p_data", 32'(data_p), 32'(mp_data));
    chk("parity_err", pe_cnt, exp_pe);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] b;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data", 32'(data), 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_flags", 32'({fe, pe, ov}), 0);
    arstn = 1;
    repeat (3) @(posedge clk);
    #1;
    rx_frame(8'hA5, 1, 0, 0, 5);
    chk("a5_latency", rise_cyc - t0, STOP_AT + 1);
    repeat (20) @(posedge clk);
    #1;
    chk("a5_hold_valid", 32'(valid), 1);
    pulse_ready(0);
    m_valid = 0;
    chk("a5_ack_valid", 32'(valid), 0);
    // glitch: 3 low cycles must be rejected as a false start
    @(posedge clk); #1;
    rx = 0;
    repeat (3) @(posedge clk);
    #1 rx = 1;
    repeat (4) @(posedge clk);
    #1 chk("glitch_busy_e5", 32'(busy), 1);
    @(posedge clk);
    #1 chk("glitch_busy_e6", 32'(busy), 0);
    repeat (10) @(posedge clk);
    #1 chk("glitch_valid", 32'(valid), 0);
    chk("glitch_err", fe_cnt, exp_fe);
    // break: bad stop bit then line held low
    fork
      rx_frame(8'h3C, 0, 1, 50, 5);
      begin
        @(posedge clk);
        @(posedge clk);
        repeat (150) @(posedge clk);
        #1 chk("break_busy", 32'(busy), 1);
        chk("break_one_fe", fe_cnt, exp_fe + 1);
      end
    join
    chk("break_idle", 32'(busy), 0);
    rx_frame(8'h81, 1, 0, 0, 2);
    rx_frame(8'h11, 1, 1, 0, 0);
    rx_frame(8'h22, 1, 0, 0, 0);
    rx_frame(8'h11, 1, 1, 0, 0);
    rx_frame(8'h22, 1, 2, 0, 0);
    p_frame(8'h07, 0);
    p_frame(8'h07, 1);
    for (int k = 0; k < 30; k++) begin
      b = 8'($urandom);
      rx_frame(b, $urandom_range(0, 7) != 0, $urandom_range(0, 2), 0, $urandom_range(0, 3));
    end
    for (int k = 0; k < 12; k++) begin
      b = 8'($urandom);
      p_frame(b, (^b) ^ ($urandom_range(0, 3) == 0));
    end
    rx_frame(8'hC3, 1, 1, 0, 0);
    // abort mid data bit 4 of an all-zero frame
    @(posedge clk); #1;
    rx = 0;
    repeat (HALF + 5 * CPB) @(posedge clk);
    #1 arstn = 0;
    rx = 1;
    #1;
    chk("mid_rst_data", 32'(data), 0);
    chk("mid_rst_valid", 32'(valid), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_flags", 32'({fe, pe, ov}), 0);
    m_valid = 0;
    m_data = 0;
    repeat (3) @(posedge clk);
    #1 arstn = 1;
    repeat (3) @(posedge clk);
    #1;
    rx_frame(8'h5A, 1, 0, 0, 2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/fpga_uart_rx.md
# fpga_uart_rx

Serial UART receiver for the FPGA UART design; the receive-side counterpart of the UART transmitter driving `uart_tx_o` on the Arty A7 top. It synchronises the asynchronous `uart_rx_i` line, detects and validates start bits, samples each bit at its midpoint, and checks optional parity and the stop bit. Each received byte is presented on a valid/ready output interface towards the top-level loopback and user logic.

## Interface
- `CLK_FREQ_HZ`, 100_000_000: system clock frequency.
- `BAUD_RATE`, 115_200: line rate; `CLKS_PER_BIT = CLK_FREQ_HZ/BAUD_RATE` (integer division, must be ≥ 4).
- `DATA_WIDTH`, 8: data bits per frame (5–9).
- `PARITY_EN`, 0: 1 = one parity bit follows the data bits.
- `PARITY_ODD`, 0: 0 = even parity, 1 = odd parity (ignored if `PARITY_EN` = 0).
- `clk_i`  in  1  system clock; all logic is on the rising edge.
- `arstn_i`  in  1  asynchronous active-low reset.
- `uart_rx_i`  in  1  asynchronous serial line; idles high.
- `data_o`  out  DATA_WIDTH  received word, LSB first on the line.
- `valid_o`  out  1  `data_o` holds an unread word.
- `ready_i`  in  1  consumer accepts the word when `valid_o && ready_i` at a rising edge.
- `busy_o`  out  1  high in every state except IDLE.
- `frame_err_o`  out  1  one-cycle pulse: stop bit sampled low.
- `parity_err_o`  out  1  one-cycle pulse: parity mismatch.
- `overrun_o`  out  1  one-cycle pulse: frame completed while `valid_o` was still high.

## Operation
- `uart_rx_i` passes through a 2-flop synchroniser; the synchronised value resets to 1. All state logic uses the synchronised line `rx_s`.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
- IDLE: a falling edge on `rx_s` (previous value 1, current value 0) clears the baud counter and moves the FSM to START.
- START: after `CLKS_PER_BIT/2` cycles, `rx_s` is sampled.
  - `rx_s` = 1: false start; return to IDLE with no flags raised.
  - `rx_s` = 0: move to DATA.
- DATA: one sample every `CLKS_PER_BIT` cycles, shifted in LSB first. A bit index counter runs from 0 to `DATA_WIDTH-1`. After the last bit the FSM moves to PARITY if `PARITY_EN` = 1, otherwise to STOP.
- PARITY: one sample; the expected bit is the XOR of the data bits, inverted when `PARITY_ODD` = 1.
- STOP: one sample at the stop-bit midpoint. The FSM returns to IDLE directly. It does not wait for the full stop bit, so it can resynchronise on the next start edge.
- Outcome of a completed frame, in priority order:
  1. Stop bit = 0: pulse `frame_err_o`, discard the word, go to WAIT_IDLE.
  2. Parity mismatch: pulse `parity_err_o` and discard the word.
  3. `valid_o` = 1 and no handshake in the same cycle: pulse `overrun_o`. The new word is dropped and `data_o` is retained.
  4. Otherwise: load `data_o` and set `valid_o`.
- WAIT_IDLE: remain here until `rx_s` = 1, then go to IDLE. A break condition (line held low) produces exactly one `frame_err_o` pulse.
- `valid_o` clears on the handshake cycle. If a handshake and a word load occur in the same cycle, the load wins: `valid_o` stays 1, `data_o` takes the new word, and no overrun is raised.

## Timing
- Reset values: `data_o` = 0, `valid_o` = 0, `busy_o` = 0, all error pulses = 0, FSM = IDLE, synchroniser = 1.
- Let E be the cycle in which the falling edge is detected on `rx_s`, i.e. two cycles after the edge on `uart_rx_i`.
- Sample points, measured from E:
  - start bit: E + `CLKS_PER_BIT/2`;
  - data bit i: E + `CLKS_PER_BIT/2` + (i+1)·`CLKS_PER_BIT`;
  - parity and stop bits follow at the same `CLKS_PER_BIT` pitch.
- `valid_o` or an error pulse is registered in the cycle after the stop-bit sample.
- `busy_o` rises in cycle E+1 and falls when the FSM re-enters IDLE.
- Reset asserted mid-frame aborts immediately with no flags raised. The first falling edge after reset release starts a new frame.

## Structure
- Package `fpga_uart_pkg` contains:
  - `uart_rx_state_t` enum;
  - function `clks_per_bit(clk_hz, baud)`;
  - shared parity calculation function, also used by the transmitter.
- Sub-module `fpga_uart_sync`: parameterisable N-stage (default 2) flop synchroniser with a parameterised reset value. It is reused for the top-level inputs.

## Test plan
All scenarios use `CLK_FREQ_HZ` = 100e6 and `BAUD_RATE` = 10e6, giving 10 clocks per bit; 8N1 unless stated.
- Send 0xA5, with `ready_i` held low. Expect `data_o` = 0xA5 and `valid_o` = 1 at E + 96. `valid_o` stays high until `ready_i` is pulsed, then clears on that cycle.
- Drive a 3-cycle low glitch on `uart_rx_i`. Expect no `valid_o`, no error pulses, and `busy_o` low again by E + 6.
- Send 0x3C with the stop bit driven low, then hold the line low for 50 cycles. Expect exactly one `frame_err_o` pulse, no `valid_o`, and the FSM in WAIT_IDLE until the line goes high. A following 0x81 is then received correctly.
- Send 0x11 then 0x22 back-to-back with `ready_i` = 0. Expect `data_o` = 0x11 retained and one `overrun_o` pulse. Repeat with `ready_i` = 1 in the load cycle and expect `data_o` = 0x22 with no overrun.
- With `PARITY_EN` = 1 and even parity, send 0x07 with parity bit 0. Expect a `parity_err_o` pulse and no `valid_o`. Send 0x07 with parity bit 1 and expect `data_o` = 0x07.
- Assert `arstn_i` during data bit 4 of a frame. Expect all outputs at their reset values. Send 0x5A after release and expect `data_o` = 0x5A.
